pedal_sensor_cond: RTL

//  Conditions raw crank sensors into the inputs consumed by desiredDrive:
//  avg_torque, cadence and not_pedaling. Measures cadence by counting

---
 rtl/pedal_sensor_cond.sv | 131 +++++++++++++
 1 files changed

// File: rtl/pedal_sensor_cond.sv
// Crank sensor conditioning: cadence per 2**CAD_WIN_W clk window, torque EMA per pulse (cad_rise 3 clks after input, avg 1 clk later).
// Outputs level-valid every clk, no backpressure; define CAD_FILT_EN to add a FILT_CYC-clk glitch filter after the synchroniser.
module pedal_sensor_cond #(
  parameter int CAD_WIN_W = 20,
  parameter int AVG_W     = 4,
  parameter int NP_THRESH = 2,
  parameter int FILT_CYC  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] torque,
  input  logic        cadence_raw,
  output logic [11:0] avg_torque,
  output logic [4:0]  cadence,
  output logic        not_pedaling
);

  localparam int         ACC_W    = 12 + AVG_W;
  localparam logic [5:0] EDGE_SAT = 6'd32;
  localparam logic [5:0] NP_T     = 6'(NP_THRESH);

  if (FILT_CYC < 1) begin : g_filt_cyc_chk
    $error("FILT_CYC must be at least 1");
  end

  logic sync1;
  logic sync2;
  logic edge_src;
  logic edge_prev;
  logic cad_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= cadence_raw;
      sync2 <= sync1;
    end
  end

`ifdef CAD_FILT_EN
  localparam int              FC_W    = $clog2(FILT_CYC + 1);
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(FILT_CYC - 1);

  logic [FC_W-1:0] filt_cnt;
  logic            cad_filt;

  // Any return to the filtered level restarts the stability count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_cnt <= '0;
      cad_filt <= 1'b0;
    end else if (sync2 == cad_filt) begin
      filt_cnt <= '0;
    end else if (filt_cnt == FC_LAST) begin
      filt_cnt <= '0;
      cad_filt <= sync2;
    end else begin
      filt_cnt <= filt_cnt + FC_W'(1);
    end
  end

  assign edge_src = cad_filt;
`else
  assign edge_src = sync2;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_prev <= 1'b0;
      cad_rise  <= 1'b0;
    end else begin
      edge_prev <= edge_src;
      cad_rise  <= edge_src & ~edge_prev;
    end
  end

  logic [CAD_WIN_W-1:0] win_cnt;
  logic                 win_term;
  logic [5:0]           edge_cnt;
  logic [6:0]           edge_sum;
  logic [5:0]           edge_next;
  logic [4:0]           cad_new;

  always_comb begin
    win_term  = &win_cnt;
    edge_sum  = {1'b0, edge_cnt} + {6'd0, cad_rise};
    edge_next = (edge_sum > {1'b0, EDGE_SAT}) ? EDGE_SAT : edge_sum[5:0];
    cad_new   = (edge_sum > 7'd31) ? 5'd31 : edge_sum[4:0];
  end

  // A rise landing on the terminal cycle belongs to the closing window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt      <= '0;
      edge_cnt     <= '0;
      cadence      <= '0;
      not_pedaling <= 1'b1;
    end else begin
      win_cnt <= win_cnt + CAD_WIN_W'(1);
      if (win_term) begin
        edge_cnt     <= '0;
        cadence      <= cad_new;
        not_pedaling <= ({1'b0, cad_new} < NP_T);
      end else begin
        edge_cnt <= edge_next;
      end
    end
  end

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_new;

  // Seeding while idle avoids a slow ramp up from a stale average.
  always_comb begin
    if (not_pedaling) acc_new = {torque, {AVG_W{1'b0}}};
    else              acc_new = acc - (acc >> AVG_W) + ACC_W'(torque);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      avg_torque <= '0;
    end else if (cad_rise) begin
      acc        <= acc_new;
      avg_torque <= acc_new[ACC_W-1:AVG_W];
    end
  end

endmodule
